// File: rtl/clk_scale_monitor.sv
// Measures the high/low phase widths of a divided clock against clk and
// reports period, duty class, lock and no-edge status.
module clk_scale_monitor #(
    parameter int CNT_W       = 16,
    parameter int LOCK_COUNT  = 4,
    parameter int TIMEOUT     = 1024,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             div_in,
    output logic [CNT_W-1:0] high_cycles,
    output logic [CNT_W-1:0] low_cycles,
    output logic [CNT_W:0]   period,
    output logic [1:0]       mode_code,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MEAS_HIGH = 2'd1,
        MEAS_LOW  = 2'd2,
        UPDATE    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT);
    localparam logic [7:0]       LOCK_VAL = 8'(LOCK_COUNT);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_d;
    logic                   w_s;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_edge;

    state_t                 r_state;
    state_t                 w_next;
    logic                   w_cap_hi;
    logic                   w_cap_lo;
    logic                   w_to;

    logic [CNT_W-1:0]       r_phase_cnt;
    logic [CNT_W-1:0]       r_hi_tmp;
    logic [CNT_W-1:0]       r_lo_tmp;
    logic [CNT_W-1:0]       r_ref_hi;
    logic [CNT_W-1:0]       r_ref_lo;
    logic [7:0]             r_run;
    logic [7:0]             w_run_nxt;
    logic                   r_seen;
    logic [1:0]             w_mode;

    // Synchronizer only obeys reset; enable=0 must not disturb it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
            r_d    <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], div_in};
            r_d    <= w_s;
        end
    end

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_rise = w_s & ~r_d;
    assign w_fall = ~w_s & r_d;
    assign w_edge = w_rise | w_fall;

    // An edge on the threshold cycle takes precedence over the timeout.
    assign w_to = !w_edge && (r_phase_cnt == TO_VAL) &&
                  ((r_state == MEAS_HIGH) || (r_state == MEAS_LOW) ||
                   ((r_state == IDLE) && r_seen));

    always_ff @(posedge clk) begin
        if (reset || !enable) r_state <= IDLE;
        else                  r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_cap_hi = 1'b0;
        w_cap_lo = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rise) w_next = MEAS_HIGH;
            end
            MEAS_HIGH: begin
                if (w_fall) begin
                    w_cap_hi = 1'b1;
                    w_next   = MEAS_LOW;
                end
            end
            MEAS_LOW: begin
                if (w_rise) begin
                    w_cap_lo = 1'b1;
                    w_next   = UPDATE;
                end
            end
            UPDATE: begin
                w_next = MEAS_HIGH;
                if (w_fall) begin
                    w_cap_hi = 1'b1;
                    w_next   = MEAS_LOW;
                end
            end
            default: w_next = IDLE;
        endcase
        if (w_to) w_next = IDLE;
    end

    always_comb begin
        w_run_nxt = r_run;
        if ((r_run == 8'd0) || (r_hi_tmp != r_ref_hi) || (r_lo_tmp != r_ref_lo))
            w_run_nxt = 8'd1;
        else if (r_run < LOCK_VAL)
            w_run_nxt = r_run + 8'd1;
    end

    always_comb begin
        w_mode = 2'd3;
        if (r_hi_tmp == r_lo_tmp)                w_mode = 2'd1;
        else if (r_hi_tmp == r_lo_tmp + CNT_ONE) w_mode = 2'd2;
    end

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            r_phase_cnt <= '0;
            r_hi_tmp    <= '0;
            r_lo_tmp    <= '0;
            r_ref_hi    <= '0;
            r_ref_lo    <= '0;
            r_run       <= 8'd0;
            r_seen      <= 1'b0;
            high_cycles <= '0;
            low_cycles  <= '0;
            period      <= '0;
            mode_code   <= 2'd0;
            meas_valid  <= 1'b0;
            locked      <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            if (w_edge)                     r_phase_cnt <= CNT_ONE;
            else if (r_phase_cnt != CNT_MAX) r_phase_cnt <= r_phase_cnt + CNT_ONE;

            if (w_cap_hi) r_hi_tmp <= r_phase_cnt;
            if (w_cap_lo) r_lo_tmp <= r_phase_cnt;

            meas_valid <= 1'b0;
            if (w_rise) timeout <= 1'b0;

            if (w_to) begin
                timeout   <= 1'b1;
                locked    <= 1'b0;
                r_run     <= 8'd0;
                mode_code <= 2'd0;
            end else if (r_state == UPDATE) begin
                high_cycles <= r_hi_tmp;
                low_cycles  <= r_lo_tmp;
                period      <= {1'b0, r_hi_tmp} + {1'b0, r_lo_tmp};
                mode_code   <= w_mode;
                meas_valid  <= 1'b1;
                r_seen      <= 1'b1;
                r_run       <= w_run_nxt;
                r_ref_hi    <= r_hi_tmp;
                r_ref_lo    <= r_lo_tmp;
                locked      <= (w_run_nxt >= LOCK_VAL);
            end
        end
    end

endmodule
